control_sequencer: RTL and testbench

- Registered successor to the combinational control decoder of the mini-MIPS core.
- Decodes one instruction per cycle through a valid/ready handshake and drives one-cycle-registered control outputs.
- Tracks the multi-cycle multiply/divide unit and back-pressures dependent instructions (mult/div/mfhi/mflo) until HI/LO is ready.
- Sits between the fetch/instruction register and the datapath/MDU.

---
 rtl/control_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_control_sequencer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Registered mini-MIPS control decoder: one instruction per cycle via valid/ready,
// with multiply/divide unit tracking that stalls HI/LO-dependent instructions.
module control_sequencer #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 16,
  parameter int CNT_W       = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_instr_valid,
  input  logic [31:0] i_instruction,
  input  logic        i_flush,
  output logic        o_instr_ready,
  output logic        o_out_valid,
  output logic        o_reg_dst,
  output logic        o_alu_src,
  output logic        o_mem_to_reg,
  output logic        o_reg_write,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic        o_branch,
  output logic        o_branch_not_equal,
  output logic        o_jump_link,
  output logic        o_mfhi_en,
  output logic        o_mflo_en,
  output logic [1:0]  o_alu_op,
  output logic        o_md_start,
  output logic [1:0]  o_md_op,
  output logic        o_md_busy,
  output logic        o_md_done,
  output logic        o_illegal
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       branch_not_equal;
    logic       jump_link;
    logic       mfhi_en;
    logic       mflo_en;
    logic [1:0] alu_op;
    logic       md_start;
    logic [1:0] md_op;
    logic       illegal;
  } ctrl_t;

  logic [5:0]     w_opcode;
  logic [5:0]     w_funct;
  logic           w_is_md_op;
  logic           w_is_hilo;
  logic           w_hazard;
  logic           w_accept;
  logic           w_commit;
  logic           w_unused_bits;
  ctrl_t          w_dec;

  state_t         r_state;
  state_t         w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic           r_md_done;
  logic           w_md_done_next;
  logic           r_out_valid;
  ctrl_t          r_ctrl;

  assign w_opcode      = i_instruction[31:26];
  assign w_funct       = i_instruction[5:0];
  assign w_unused_bits = ^i_instruction[25:6];

  assign w_is_md_op = (w_opcode == OP_RTYPE) && (w_funct[5:2] == 4'b0110);
  assign w_is_hilo  = (w_opcode == OP_RTYPE) &&
                      ((w_funct == FN_MFHI) || (w_funct == FN_MFLO));
  assign w_hazard   = w_is_md_op || w_is_hilo;

  // Only HI/LO consumers and new MDU ops wait; everything else streams through.
  assign o_instr_ready = !((r_state == S_BUSY) && w_hazard);
  assign w_accept      = i_instr_valid && o_instr_ready;
  assign w_commit      = w_accept && !i_flush;

  always_comb begin
    w_dec = '0;
    case (w_opcode)
      OP_RTYPE: begin
        if (w_is_md_op) begin
          w_dec.md_start = 1'b1;
          w_dec.md_op    = w_funct[1:0];
        end else if (w_funct == FN_MFHI) begin
          w_dec.reg_write = 1'b1;
          w_dec.reg_dst   = 1'b1;
          w_dec.mfhi_en   = 1'b1;
        end else if (w_funct == FN_MFLO) begin
          w_dec.reg_write = 1'b1;
          w_dec.reg_dst   = 1'b1;
          w_dec.mflo_en   = 1'b1;
        end else begin
          w_dec.reg_dst   = 1'b1;
          w_dec.reg_write = 1'b1;
          w_dec.alu_op    = 2'b10;
        end
      end
      OP_LW: begin
        w_dec.alu_src    = 1'b1;
        w_dec.mem_to_reg = 1'b1;
        w_dec.reg_write  = 1'b1;
        w_dec.mem_read   = 1'b1;
      end
      OP_SW: begin
        w_dec.alu_src   = 1'b1;
        w_dec.mem_write = 1'b1;
      end
      OP_JAL: begin
        w_dec.reg_write = 1'b1;
        w_dec.jump_link = 1'b1;
      end
      OP_BEQ: begin
        w_dec.branch = 1'b1;
        w_dec.alu_op = 2'b01;
      end
      OP_BNE: begin
        w_dec.branch_not_equal = 1'b1;
        w_dec.alu_op           = 2'b01;
      end
      OP_ADDI: begin
        w_dec.alu_src   = 1'b1;
        w_dec.reg_write = 1'b1;
      end
      default: w_dec.illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_md_done_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_commit && w_is_md_op) begin
          w_state_next = S_BUSY;
          w_cnt_next   = w_funct[1] ? DIV_LOAD : MULT_LOAD;
        end
      end
      S_BUSY: begin
        if (r_cnt == '0) begin
          w_state_next   = S_IDLE;
          w_md_done_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_md_done <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_md_done <= w_md_done_next;
    end
  end

  // A flushed or absent instruction registers an all-zero control word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_ctrl      <= '0;
    end else begin
      r_out_valid <= w_commit;
      r_ctrl      <= w_commit ? w_dec : '0;
    end
  end

  assign o_out_valid        = r_out_valid;
  assign o_reg_dst          = r_ctrl.reg_dst;
  assign o_alu_src          = r_ctrl.alu_src;
  assign o_mem_to_reg       = r_ctrl.mem_to_reg;
  assign o_reg_write        = r_ctrl.reg_write;
  assign o_mem_read         = r_ctrl.mem_read;
  assign o_mem_write        = r_ctrl.mem_write;
  assign o_branch           = r_ctrl.branch;
  assign o_branch_not_equal = r_ctrl.branch_not_equal;
  assign o_jump_link        = r_ctrl.jump_link;
  assign o_mfhi_en          = r_ctrl.mfhi_en;
  assign o_mflo_en          = r_ctrl.mflo_en;
  assign o_alu_op           = r_ctrl.alu_op;
  assign o_md_start         = r_ctrl.md_start;
  assign o_md_op            = r_ctrl.md_op;
  assign o_illegal          = r_ctrl.illegal;
  assign o_md_busy          = (r_state == S_BUSY);
  assign o_md_done          = r_md_done;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed scenarios plus random traffic, compared
// cycle by cycle against a behavioural decode/latency model.
module tb_control_sequencer;

  localparam int MULT_CYCLES = 4;
  localparam int DIV_CYCLES  = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instruction = 32'h0;
  logic        flush = 1'b0;

  logic instr_ready, out_valid, reg_dst, alu_src, mem_to_reg, reg_write, mem_read;
  logic mem_write, branch, branch_not_equal, jump_link, mfhi_en, mflo_en;
  logic [1:0] alu_op, md_op;
  logic md_start, md_busy, md_done, illegal;

  always #5 clk = ~clk;

  control_sequencer #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (5)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_instr_valid     (instr_valid),
    .i_instruction     (instruction),
    .i_flush           (flush),
    .o_instr_ready     (instr_ready),
    .o_out_valid       (out_valid),
    .o_reg_dst         (reg_dst),
    .o_alu_src         (alu_src),
    .o_mem_to_reg      (mem_to_reg),
    .o_reg_write       (reg_write),
    .o_mem_read        (mem_read),
    .o_mem_write       (mem_write),
    .o_branch          (branch),
    .o_branch_not_equal(branch_not_equal),
    .o_jump_link       (jump_link),
    .o_mfhi_en         (mfhi_en),
    .o_mflo_en         (mflo_en),
    .o_alu_op          (alu_op),
    .o_md_start        (md_start),
    .o_md_op           (md_op),
    .o_md_busy         (md_busy),
    .o_md_done         (md_done),
    .o_illegal         (illegal)
  );

  logic [19:0] obs;
  assign obs = {out_valid, reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
                branch, branch_not_equal, jump_link, mfhi_en, mflo_en, alu_op,
                md_start, md_op, md_busy, md_done, illegal};

  typedef struct packed {
    logic       reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write;
    logic       branch, bne, jal, mfhi, mflo;
    logic [1:0] alu_op;
    logic       md_start;
    logic [1:0] md_op;
    logic       illegal;
  } dec_t;

  int   vectors = 0;
  int   miscompares = 0;
  int   m_busy_left = 0;
  logic m_done = 1'b0;
  logic m_ov = 1'b0;
  dec_t m_dec = '0;
  logic exp_ready, obs_ready;

  function automatic logic [31:0] mk_r(input logic [5:0] fn);
    logic [31:0] w;
    w = $urandom;
    w[31:26] = 6'h00;
    w[5:0] = fn;
    return w;
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op);
    logic [31:0] w;
    w = $urandom;
    w[31:26] = op;
    return w;
  endfunction

  function automatic logic is_md(input logic [31:0] ins);
    return (ins[31:26] == 6'h00) && (ins[5:0] inside {6'h18, 6'h19, 6'h1A, 6'h1B});
  endfunction

  function automatic logic is_hazard(input logic [31:0] ins);
    return is_md(ins) || ((ins[31:26] == 6'h00) && (ins[5:0] inside {6'h10, 6'h12}));
  endfunction

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t d;
    logic [5:0] op, fn;
    d = '0;
    op = ins[31:26];
    fn = ins[5:0];
    case (op)
      6'h00: begin
        if (is_md(ins)) begin d.md_start = 1; d.md_op = fn[1:0]; end
        else if (fn == 6'h10) begin d.reg_write = 1; d.reg_dst = 1; d.mfhi = 1; end
        else if (fn == 6'h12) begin d.reg_write = 1; d.reg_dst = 1; d.mflo = 1; end
        else begin d.reg_write = 1; d.reg_dst = 1; d.alu_op = 2'b10; end
      end
      6'h23: begin d.alu_src = 1; d.mem_to_reg = 1; d.reg_write = 1; d.mem_read = 1; end
      6'h2B: begin d.alu_src = 1; d.mem_write = 1; end
      6'h03: begin d.reg_write = 1; d.jal = 1; end
      6'h04: begin d.branch = 1; d.alu_op = 2'b01; end
      6'h05: begin d.bne = 1; d.alu_op = 2'b01; end
      6'h08: begin d.alu_src = 1; d.reg_write = 1; end
      default: d.illegal = 1;
    endcase
    return d;
  endfunction

  function automatic logic [19:0] exp_word();
    return {m_ov, m_dec.reg_dst, m_dec.alu_src, m_dec.mem_to_reg, m_dec.reg_write,
            m_dec.mem_read, m_dec.mem_write, m_dec.branch, m_dec.bne, m_dec.jal,
            m_dec.mfhi, m_dec.mflo, m_dec.alu_op, m_dec.md_start, m_dec.md_op,
            (m_busy_left > 0), m_done, m_dec.illegal};
  endfunction

  task automatic model_reset();
    m_busy_left = 0;
    m_done = 1'b0;
    m_ov = 1'b0;
    m_dec = '0;
  endtask

  // Applies one cycle of stimulus (called just after a falling edge) and advances the model.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic f);
    logic commit;
    instr_valid = v;
    instruction = ins;
    flush = f;
    #1;
    exp_ready = !((m_busy_left > 0) && is_hazard(ins));
    obs_ready = instr_ready;
    commit = v && exp_ready && !f;
    @(posedge clk);
    if (m_busy_left > 0) begin
      m_busy_left--;
      m_done = (m_busy_left == 0);
    end else begin
      m_done = 1'b0;
      if (commit && is_md(ins)) m_busy_left = ins[1] ? DIV_CYCLES : MULT_CYCLES;
    end
    m_ov = commit;
    m_dec = commit ? decode(ins) : '0;
    @(negedge clk);
    if (commit) $display("accept t=%0t instr=%08h busy_left=%0d", $time, ins, m_busy_left);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (obs !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_async got=%05h required=%05h", obs, 20'h0);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (obs !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_hold got=%05h required=%05h", obs, 20'h0);
    end
    rst_n = 1'b1;
    model_reset();
    cycle(1'b0, 32'h0, 1'b0);
    vectors++;
    if ({obs_ready, obs} !== {exp_ready, exp_word()}) begin
      miscompares++;
      $display("FAIL reset_idle got=%b/%05h required=%b/%05h", obs_ready, obs, exp_ready, exp_word());
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] prog [4];
    prog[0] = mk_i(6'h23);
    prog[1] = mk_i(6'h2B);
    prog[2] = mk_i(6'h04);
    prog[3] = mk_i(6'h08);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, prog[i], 1'b0);
      vectors++;
      if ({obs_ready, obs} !== {exp_ready, exp_word()} || out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b[%0d] got=%b/%05h required=%b/%05h", i, obs_ready, obs, exp_ready, exp_word());
      end
    end
    cycle(1'b0, 32'h0, 1'b0);
    vectors++;
    if (obs !== exp_word() || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_gap got=%05h required=%05h", obs, exp_word());
    end
  endtask

  task automatic test_mult_mfhi();
    int   stalls;
    logic done_prev;
    logic accepted;
    stalls = 0;
    accepted = 1'b0;
    cycle(1'b1, mk_r(6'h18), 1'b0);
    vectors++;
    if ({obs_ready, obs} !== {exp_ready, exp_word()} || md_start !== 1'b1 || md_op !== 2'b00) begin
      miscompares++;
      $display("FAIL mult_start got=%b/%05h required=%b/%05h", obs_ready, obs, exp_ready, exp_word());
    end
    for (int i = 0; i < 20 && !accepted; i++) begin
      done_prev = md_done;
      cycle(1'b1, mk_r(6'h10), 1'b0);
      vectors++;
      if ({obs_ready, obs} !== {exp_ready, exp_word()}) begin
        miscompares++;
        $display("FAIL mfhi_wait[%0d] got=%b/%05h required=%b/%05h", i, obs_ready, obs, exp_ready, exp_word());
      end
      if (obs_ready) begin
        accepted = 1'b1;
        vectors++;
        if (done_prev !== 1'b1 || mfhi_en !== 1'b1 || md_busy !== 1'b0) begin
          miscompares++;
          $display("FAIL mfhi_accept got done=%b mfhi_en=%b busy=%b required 1 1 0", done_prev, mfhi_en, md_busy);
        end
      end else begin
        stalls++;
      end
    end
    vectors++;
    if (stalls != MULT_CYCLES || !accepted) begin
      miscompares++;
      $display("FAIL mult_stalls got=%0d accepted=%b required=%0d", stalls, accepted, MULT_CYCLES);
    end
  endtask

  task automatic test_div_add();
    int busy_cycles;
    busy_cycles = 0;
    cycle(1'b1, mk_r(6'h1A), 1'b0);
    vectors++;
    if ({obs_ready, obs} !== {exp_ready, exp_word()} || md_op !== 2'b10) begin
      miscompares++;
      $display("FAIL div_start got=%b/%05h required=%b/%05h", obs_ready, obs, exp_ready, exp_word());
    end
    if (md_busy) busy_cycles++;
    cycle(1'b1, mk_r(6'h20), 1'b0);
    vectors++;
    if ({obs_ready, obs} !== {exp_ready, exp_word()} || obs_ready !== 1'b1 ||
        alu_op !== 2'b10 || reg_dst !== 1'b1) begin
      miscompares++;
      $display("FAIL add_in_busy got=%b/%05h required=%b/%05h", obs_ready, obs, exp_ready, exp_word());
    end
    if (md_busy) busy_cycles++;
    for (int i = 0; i < 40 && md_busy; i++) begin
      cycle(1'b0, 32'h0, 1'b0);
      vectors++;
      if (obs !== exp_word()) begin
        miscompares++;
        $display("FAIL div_drain[%0d] got=%05h required=%05h", i, obs, exp_word());
      end
      if (md_busy) busy_cycles++;
    end
    vectors++;
    if (busy_cycles != DIV_CYCLES) begin
      miscompares++;
      $display("FAIL div_busy_len got=%0d required=%0d", busy_cycles, DIV_CYCLES);
    end
  endtask

  task automatic test_illegal();
    cycle(1'b1, mk_i(6'h3F), 1'b0);
    vectors++;
    if ({obs_ready, obs} !== {exp_ready, exp_word()} || obs !== 20'h80001) begin
      miscompares++;
      $display("FAIL illegal got=%05h required=%05h", obs, 20'h80001);
    end
  endtask

  task automatic test_flush();
    cycle(1'b1, mk_r(6'h1B), 1'b1);
    vectors++;
    if ({obs_ready, obs} !== {exp_ready, exp_word()} || obs !== 20'h0) begin
      miscompares++;
      $display("FAIL flush_divu got=%05h required=%05h", obs, 20'h0);
    end
    cycle(1'b0, 32'h0, 1'b0);
    vectors++;
    if (md_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_busy got=%b required=0", md_busy);
    end
  endtask

  task automatic test_reset_mid_busy();
    int dones;
    dones = 0;
    cycle(1'b1, mk_r(6'h18), 1'b0);
    cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0);
    vectors++;
    if (md_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_busy got=%b required=1", md_busy);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (obs !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_mid_busy got=%05h required=%05h", obs, 20'h0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 32'h0, 1'b0);
      if (md_done) dones++;
      vectors++;
      if (obs !== exp_word()) begin
        miscompares++;
        $display("FAIL post_reset[%0d] got=%05h required=%05h", i, obs, exp_word());
      end
    end
    vectors++;
    if (dones != 0) begin
      miscompares++;
      $display("FAIL post_reset_done got=%0d required=0", dones);
    end
    cycle(1'b1, mk_r(6'h12), 1'b0);
    vectors++;
    if ({obs_ready, obs} !== {exp_ready, exp_word()} || obs_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_ready got=%b/%05h required=%b/%05h", obs_ready, obs, exp_ready, exp_word());
    end
  endtask

  task automatic test_random();
    logic [5:0]  ops [10];
    logic [5:0]  fns [10];
    logic [31:0] ins;
    ops = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h03, 6'h04, 6'h05, 6'h08, 6'h3F};
    fns = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h12, 6'h20, 6'h22, 6'h2A, 6'h00};
    for (int i = 0; i < 400; i++) begin
      ins = mk_i(ops[$urandom_range(0, 9)]);
      if ($urandom_range(0, 9) == 0) ins[31:26] = 6'($urandom_range(0, 63));
      if (ins[31:26] == 6'h00) ins[5:0] = fns[$urandom_range(0, 9)];
      cycle($urandom_range(0, 3) != 0, ins, $urandom_range(0, 9) == 0);
      vectors++;
      if ({obs_ready, obs} !== {exp_ready, exp_word()}) begin
        miscompares++;
        $display("FAIL random[%0d] instr=%08h got=%b/%05h required=%b/%05h",
                 i, ins, obs_ready, obs, exp_ready, exp_word());
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_mult_mfhi();
    test_div_add();
    test_illegal();
    test_flush();
    test_reset_mid_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
